// File: rtl/adsr_envelope_generator_if.sv
// Note/parameter inputs and gain/status outputs of one ADSR voice envelope.
// The master side is the note/parameter decoder and the slave side is the envelope generator.
interface adsr_envelope_generator_if #(
    parameter int ENV_WIDTH   = 16,
    parameter int PARAM_WIDTH = 7
);
    logic                   sample_tick;
    logic                   note_on;
    logic                   note_off;
    logic [PARAM_WIDTH-1:0] attack;
    logic [PARAM_WIDTH-1:0] decay;
    logic [PARAM_WIDTH-1:0] sustain;
    logic [PARAM_WIDTH-1:0] release_rate;
    logic [ENV_WIDTH-1:0]   envelope;
    logic [2:0]             stage;
    logic                   active;
    logic                   done;

    modport master (
        output sample_tick, note_on, note_off, attack, decay, sustain, release_rate,
        input  envelope, stage, active, done
    );

    modport slave (
        input  sample_tick, note_on, note_off, attack, decay, sustain, release_rate,
        output envelope, stage, active, done
    );
endinterface

// File: rtl/adsr_envelope_generator.sv
// Linear per-voice ADSR envelope stepped by the audio sample strobe.
// Each step moves the envelope by 2^STEP_SHIFT and clamps it at the stage target.
module adsr_envelope_generator #(
    parameter int ENV_WIDTH   = 16,
    parameter int PARAM_WIDTH = 7,
    parameter int STEP_SHIFT  = 8
) (
    input  logic                       clock,
    input  logic                       reset_l,
    adsr_envelope_generator_if.slave   port
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } stage_t;

    localparam int SW = ENV_WIDTH + 2;
    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;
    localparam logic signed [SW-1:0] STEP_S =
        {{(ENV_WIDTH + 1 - STEP_SHIFT){1'b0}}, 1'b1, {STEP_SHIFT{1'b0}}};

    // Saturating step helpers: widened signed math so the envelope never wraps.
    function automatic logic [ENV_WIDTH-1:0] sat_step_up(input logic [ENV_WIDTH-1:0] env);
        logic signed [SW-1:0] sum;
        sum = $signed({2'b00, env}) + STEP_S;
        if (sum > $signed({2'b00, ENV_MAX})) return ENV_MAX;
        return sum[ENV_WIDTH-1:0];
    endfunction

    function automatic logic [ENV_WIDTH-1:0] sat_step_down(input logic [ENV_WIDTH-1:0] env,
                                                           input logic [ENV_WIDTH-1:0] floor_lvl);
        logic signed [SW-1:0] diff;
        diff = $signed({2'b00, env}) - STEP_S;
        if (diff < $signed({2'b00, floor_lvl})) return floor_lvl;
        return diff[ENV_WIDTH-1:0];
    endfunction

    stage_t                 stage_q, stage_d;
    logic [ENV_WIDTH-1:0]   env_q, env_d;
    logic [PARAM_WIDTH-1:0] presc_q, presc_d;
    logic                   done_q, done_d;

    logic [ENV_WIDTH-1:0]   sus_level;
    logic [PARAM_WIDTH-1:0] rate;
    logic [PARAM_WIDTH:0]   presc_inc;
    logic                   fire;
    logic                   zero_rate;

    // Replicating the sustain bits spreads 0..127 evenly onto 0x0000..0xFFFF.
    assign sus_level = {port.sustain, port.sustain, port.sustain[PARAM_WIDTH-1 -: 2]};
    assign presc_inc = {1'b0, presc_q} + 1'b1;
    assign fire      = port.sample_tick && (presc_inc >= {1'b0, rate});
    assign zero_rate = (rate == '0);

    always_comb begin
        rate = '0;
        case (stage_q)
            ST_ATTACK:  rate = port.attack;
            ST_DECAY:   rate = port.decay;
            ST_RELEASE: rate = port.release_rate;
            default:    rate = '0;
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        env_d   = env_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        case (stage_q)
            ST_IDLE: env_d = '0;
            ST_ATTACK: begin
                if (port.sample_tick) presc_d = presc_inc[PARAM_WIDTH-1:0];
                if (fire) begin
                    presc_d = '0;
                    env_d   = zero_rate ? ENV_MAX : sat_step_up(env_q);
                    if (env_d == ENV_MAX) stage_d = ST_DECAY;
                end
            end
            ST_DECAY: begin
                if (port.sample_tick) presc_d = presc_inc[PARAM_WIDTH-1:0];
                if (port.sample_tick && env_q <= sus_level) begin
                    env_d   = sus_level;
                    stage_d = ST_SUSTAIN;
                end else if (fire) begin
                    presc_d = '0;
                    env_d   = zero_rate ? sus_level : sat_step_down(env_q, sus_level);
                    if (env_d == sus_level) stage_d = ST_SUSTAIN;
                end
            end
            ST_SUSTAIN: env_d = sus_level;
            ST_RELEASE: begin
                if (port.sample_tick) presc_d = presc_inc[PARAM_WIDTH-1:0];
                if (fire) begin
                    presc_d = '0;
                    env_d   = zero_rate ? '0 : sat_step_down(env_q, '0);
                    if (env_d == '0) begin
                        stage_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                stage_d = ST_IDLE;
                env_d   = '0;
            end
        endcase

        // Retrigger keeps the current level; note_on outranks note_off.
        if (port.note_on) begin
            stage_d = ST_ATTACK;
            presc_d = '0;
        end else if (port.note_off &&
                     (stage_q == ST_ATTACK || stage_q == ST_DECAY || stage_q == ST_SUSTAIN)) begin
            stage_d = ST_RELEASE;
        end
        if (stage_d != stage_q) presc_d = '0;
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            stage_q <= ST_IDLE;
            env_q   <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            env_q   <= env_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign port.envelope = env_q;
    assign port.stage    = stage_q;
    assign port.active   = (stage_q != ST_IDLE);
    assign port.done     = done_q;
endmodule

// File: tb/tb_adsr_envelope_generator.sv
// Directed and randomized bench for adsr_envelope_generator against a level/target reference model.
module tb_adsr_envelope_generator;
    logic clock   = 1'b0;
    logic reset_l = 1'b0;

    adsr_envelope_generator_if #(.ENV_WIDTH(16), .PARAM_WIDTH(7)) bus ();

    adsr_envelope_generator #(.ENV_WIDTH(16), .PARAM_WIDTH(7), .STEP_SHIFT(8)) dut (
        .clock   (clock),
        .reset_l (reset_l),
        .port    (bus.slave)
    );

    always #10 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: stage numbers follow the output encoding 0..4.
    int m_env, m_stage, m_presc, m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_env = 0; m_stage = 0; m_presc = 0; m_done = 0;
    endtask

    function automatic int sus_of(input int s);
        return s * 512 + s * 4 + (s >> 5);
    endfunction

    task automatic model_step();
        int sus, rate, nenv, nst, npre, ndone;
        bit tick, fire;
        sus   = sus_of(int'(bus.sustain));
        tick  = bus.sample_tick;
        nenv  = m_env; nst = m_stage; npre = m_presc; ndone = 0;
        rate  = (m_stage == 1) ? int'(bus.attack) :
                (m_stage == 2) ? int'(bus.decay)  :
                (m_stage == 4) ? int'(bus.release_rate) : 0;
        fire  = tick && (m_presc + 1 >= rate);
        if (tick && m_stage inside {1, 2, 4}) npre = m_presc + 1;
        if (m_stage == 0) nenv = 0;
        else if (m_stage == 3) nenv = sus;
        else if (m_stage == 1 && fire) begin
            npre = 0;
            nenv = (rate == 0 || m_env + 256 > 65535) ? 65535 : m_env + 256;
            if (nenv == 65535) nst = 2;
        end else if (m_stage == 2 && tick && m_env <= sus) begin
            nenv = sus; nst = 3;
        end else if (m_stage == 2 && fire) begin
            npre = 0;
            nenv = (rate == 0 || m_env - 256 < sus) ? sus : m_env - 256;
            if (nenv == sus) nst = 3;
        end else if (m_stage == 4 && fire) begin
            npre = 0;
            nenv = (rate == 0 || m_env - 256 < 0) ? 0 : m_env - 256;
            if (nenv == 0) begin nst = 0; ndone = 1; end
        end
        if (bus.note_on) begin nst = 1; npre = 0; end
        else if (bus.note_off && m_stage inside {1, 2, 3}) nst = 4;
        if (nst != m_stage) npre = 0;
        m_env = nenv; m_stage = nst; m_presc = npre; m_done = ndone;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_env"},    32'(bus.envelope), 32'(m_env));
        chk({tag, "_stage"},  32'(bus.stage),    32'(m_stage));
        chk({tag, "_active"}, 32'(bus.active),   32'(m_stage != 0));
        chk({tag, "_done"},   32'(bus.done),     32'(m_done));
    endtask

    task automatic cycle(input bit tick, input bit on, input bit off);
        @(negedge clock);
        bus.sample_tick = tick; bus.note_on = on; bus.note_off = off;
        @(posedge clock);
        model_step();
        #1;
        check_model("model");
        bus.sample_tick = 1'b0; bus.note_on = 1'b0; bus.note_off = 1'b0;
    endtask

    initial begin
        int done_cnt, done_at;
        bus.sample_tick = 0; bus.note_on = 0; bus.note_off = 0;
        bus.attack = 0; bus.decay = 0; bus.sustain = 0; bus.release_rate = 0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock) reset_l = 1'b1;
        #1;
        chk("rst_env", 32'(bus.envelope), 32'h0);
        chk("rst_stage", 32'(bus.stage), 32'd0);
        chk("rst_active", 32'(bus.active), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);

        // Attack at one tick per step.
        bus.attack = 1; bus.decay = 2; bus.sustain = 64; bus.release_rate = 3;
        cycle(0, 1, 0);
        chk("atk_start_stage", 32'(bus.stage), 32'd1);
        for (int i = 0; i < 255; i++) cycle(1, 0, 0);
        chk("atk_255", 32'(bus.envelope), 32'hFF00);
        cycle(1, 0, 0);
        chk("atk_256_env", 32'(bus.envelope), 32'hFFFF);
        chk("atk_256_stage", 32'(bus.stage), 32'd2);

        // Decay by 2 ticks per step down to the sustain level.
        for (int i = 0; i < 253; i++) cycle(1, 0, 0);
        chk("dec_253", 32'(bus.envelope), 32'h81FF);
        cycle(1, 0, 0);
        chk("dec_end_env", 32'(bus.envelope), 32'h8102);
        chk("dec_end_stage", 32'(bus.stage), 32'd3);

        bus.sustain = 127;
        cycle(0, 0, 0);
        chk("sus_track", 32'(bus.envelope), 32'hFFFF);
        bus.sustain = 64;
        cycle(0, 0, 0);
        chk("sus_back", 32'(bus.envelope), 32'h8102);

        // Release at 3 ticks per step: 130 steps from 0x8102.
        cycle(0, 0, 1);
        chk("rel_stage", 32'(bus.stage), 32'd4);
        done_cnt = 0; done_at = -1;
        for (int t = 1; t <= 400; t++) begin
            cycle(1, 0, 0);
            if (bus.done) begin done_cnt++; done_at = t; end
        end
        chk("rel_done_cnt", 32'(done_cnt), 32'd1);
        chk("rel_done_tick", 32'(done_at), 32'd390);
        chk("rel_stage_idle", 32'(bus.stage), 32'd0);
        chk("rel_active", 32'(bus.active), 32'd0);
        chk("rel_env", 32'(bus.envelope), 32'h0);

        // Zero rates jump straight to each target.
        bus.attack = 0; bus.decay = 0; bus.release_rate = 0; bus.sustain = 0;
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        chk("zr_atk_env", 32'(bus.envelope), 32'hFFFF);
        chk("zr_atk_stage", 32'(bus.stage), 32'd2);
        cycle(1, 0, 0);
        chk("zr_dec_env", 32'(bus.envelope), 32'h0);
        chk("zr_dec_stage", 32'(bus.stage), 32'd3);
        cycle(0, 0, 1);
        cycle(1, 0, 0);
        chk("zr_rel_done", 32'(bus.done), 32'd1);
        chk("zr_rel_stage", 32'(bus.stage), 32'd0);

        // Simultaneous on/off, then retrigger from the release level.
        cycle(0, 1, 1);
        chk("onoff_stage", 32'(bus.stage), 32'd1);
        bus.attack = 1; bus.release_rate = 5;
        for (int i = 0; i < 64; i++) cycle(1, 0, 0);
        chk("retrig_lvl", 32'(bus.envelope), 32'h4000);
        cycle(0, 0, 1);
        chk("retrig_rel", 32'(bus.stage), 32'd4);
        cycle(0, 1, 0);
        chk("retrig_stage", 32'(bus.stage), 32'd1);
        chk("retrig_env", 32'(bus.envelope), 32'h4000);
        cycle(1, 0, 0);
        chk("retrig_step", 32'(bus.envelope), 32'h4100);

        // Asynchronous reset in the middle of decay.
        bus.attack = 0; bus.decay = 5; bus.sustain = 10;
        cycle(1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0);
        chk("arst_pre_stage", 32'(bus.stage), 32'd2);
        #5 reset_l = 1'b0;
        #1;
        chk("arst_env", 32'(bus.envelope), 32'h0);
        chk("arst_stage", 32'(bus.stage), 32'd0);
        chk("arst_active", 32'(bus.active), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        model_reset();
        @(negedge clock) reset_l = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        chk("arst_idle", 32'(bus.stage), 32'd0);

        // Randomized notes, ticks and parameter changes against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                bus.attack       = 7'($urandom_range(0, 3));
                bus.decay        = 7'($urandom_range(0, 3));
                bus.release_rate = 7'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 31) == 0) bus.sustain = 7'($urandom_range(0, 127));
            cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 149) == 0),
                  bit'($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
